spi_reg_target: RTL

- Parametrised SPI target for the tiny-tapeout wrapper family, servicing a configurable register file: NUM_CFG read/write config registers and NUM_STATUS read-only status registers, each REG_WIDTH bits.
- Supports all four SPI modes, burst transfers with address auto-increment and wrap, and a per-write strobe.
- Sits behind the existing 2-stage input synchronizers and runs entirely in the system clk domain, oversampling spi_clk.
- No limit tying NUM_CFG to NUM_STATUS.

---
 rtl/spi_reg_target_if.sv | 12 +
 rtl/spi_reg_target.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/spi_reg_target_if.sv
// SPI bus bundle between an SPI host and spi_reg_target.
// The mode pins travel with the bus because they describe how the bus is clocked.
interface spi_reg_target_if;
  logic [1:0] mode;
  logic       spi_cs_n;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso;

  modport master (output mode, output spi_cs_n, output spi_clk, output spi_mosi, input spi_miso);
  modport slave  (input mode, input spi_cs_n, input spi_clk, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_reg_target.sv
// SPI target with a config/status register file, oversampling a synchronized spi_clk.
// Supports all four SPI modes and burst transfers with address auto-increment and wrap.
module spi_reg_target #(
  parameter int NUM_CFG    = 16,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            ena,
  spi_reg_target_if.slave                 bus,
  output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  output logic                            wr_pulse,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic                            busy
);

  localparam int TOTAL     = NUM_CFG + NUM_STATUS;
  localparam int NUM_SLOTS = 1 << ADDR_WIDTH;
  localparam int CNT_W     = (REG_WIDTH > 8) ? $clog2(REG_WIDTH) : 3;
  localparam logic [CNT_W-1:0]      CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0]      WORD_LAST = CNT_W'(REG_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(TOTAL - 1);
  localparam logic [ADDR_WIDTH:0]   CFG_END   = (ADDR_WIDTH + 1)'(NUM_CFG);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                state;
  logic                  spi_clk_d;
  logic                  rw;
  logic                  skip_shift;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CNT_W-1:0]      bit_cnt;
  logic [REG_WIDTH-2:0]  rx_sr;
  logic [REG_WIDTH-1:0]  tx_sr;

  logic                  cpol, cpha;
  logic                  leading_edge, trailing_edge, sample_edge, shift_edge;
  logic [ADDR_WIDTH-1:0] cmd_addr, next_addr;
  logic [REG_WIDTH-1:0]  rx_word;
  logic                  word_done, cfg_commit;
  logic [REG_WIDTH-1:0]  reg_view [NUM_SLOTS];

  assign cpol = bus.mode[1];
  assign cpha = bus.mode[0];

  assign leading_edge  = !bus.spi_cs_n && (spi_clk_d == cpol) && (bus.spi_clk != cpol);
  assign trailing_edge = !bus.spi_cs_n && (spi_clk_d != cpol) && (bus.spi_clk == cpol);
  assign sample_edge   = cpha ? trailing_edge : leading_edge;
  assign shift_edge    = cpha ? leading_edge  : trailing_edge;

  // The address register doubles as the command shifter; only the low bits survive.
  assign cmd_addr   = ADDR_WIDTH'({addr, bus.spi_mosi});
  assign next_addr  = (addr == ADDR_LAST) ? '0 : addr + ADDR_WIDTH'(1);
  assign rx_word    = {rx_sr, bus.spi_mosi};
  assign word_done  = (state == DATA) && sample_edge && (bit_cnt == WORD_LAST);
  assign cfg_commit = word_done && rw && ({1'b0, addr} < CFG_END);

  // Flat read map covering the full address space; unmapped slots read as zero.
  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_view
      if (gi < NUM_CFG) begin : g_cfg
        assign reg_view[gi] = config_regs[gi*REG_WIDTH +: REG_WIDTH];
      end else if (gi < TOTAL) begin : g_status
        assign reg_view[gi] = status_regs[(gi-NUM_CFG)*REG_WIDTH +: REG_WIDTH];
      end else begin : g_empty
        assign reg_view[gi] = '0;
      end
    end
  endgenerate

  assign busy         = (state != IDLE);
  assign bus.spi_miso = (state == DATA && !rw) ? tx_sr[REG_WIDTH-1] : 1'b0;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= IDLE;
      spi_clk_d   <= bus.mode[1];
      rw          <= 1'b0;
      skip_shift  <= 1'b0;
      addr        <= '0;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      wr_pulse    <= 1'b0;
      wr_addr     <= '0;
      config_regs <= '0;
    end else if (ena) begin
      spi_clk_d <= bus.spi_clk;
      wr_pulse  <= 1'b0;
      if (bus.spi_cs_n) begin
        state      <= IDLE;
        bit_cnt    <= '0;
        skip_shift <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= CMD;
            bit_cnt <= '0;
          end
          CMD: begin
            if (sample_edge) begin
              addr <= cmd_addr;
              if (bit_cnt == '0) rw <= bus.spi_mosi;
              if (bit_cnt == CMD_LAST) begin
                state      <= DATA;
                bit_cnt    <= '0;
                skip_shift <= 1'b1;
                if (!rw) tx_sr <= reg_view[cmd_addr];
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          DATA: begin
            if (sample_edge) begin
              rx_sr <= rx_word[REG_WIDTH-2:0];
              if (bit_cnt == WORD_LAST) begin
                addr       <= next_addr;
                bit_cnt    <= '0;
                skip_shift <= 1'b1;
                if (!rw) tx_sr <= reg_view[next_addr];
                if (cfg_commit) begin
                  wr_pulse <= 1'b1;
                  wr_addr  <= addr;
                end
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end else if (shift_edge && !rw) begin
              // Hold the freshly loaded MSB through the first shift edge after a load.
              if (skip_shift) skip_shift <= 1'b0;
              else            tx_sr      <= tx_sr << 1;
            end
          end
          default: state <= IDLE;
        endcase
      end
      for (int i = 0; i < NUM_CFG; i++) begin
        if (cfg_commit && addr == ADDR_WIDTH'(i))
          config_regs[i*REG_WIDTH +: REG_WIDTH] <= rx_word;
      end
    end
  end

endmodule
